load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the CPU's word-wide data memory port. It accepts byte/halfword/word load and store requests from the execute stage and drives the memory's registered-address, single-port interface. The memory has a one-cycle read latency and no byte enables, so sub-word stores are done as read-modify-write. Loaded data is sign- or zero-extended, and misaligned accesses are rejected.

## Interface
- ADDR_WIDTH, 10, memory word-address bits; memory holds 2**ADDR_WIDTH 32-bit words
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; a request transfers on a clk edge with req_valid&req_ready
- req_op  in  4  [3]=store, [2]=unsigned (loads only), [1:0]=size: 00 byte, 01 half, 10 word, 11 reserved
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse, no backpressure
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or reserved-size request; valid with resp_valid
- mem_addr  out  ADDR_WIDTH  word address = latched addr[ADDR_WIDTH+1:2]; upper bits ignored
- mem_data_in  out  32  write data
- mem_wr_rd  out  1  0 = write at next edge, 1 = read
- mem_data_out  in  32  word addressed by the memory's registered address, valid the cycle after the address is presented

## Operation
- The unit latches op, addr and wdata on acceptance.
- Byte lanes are little-endian: byte k = bits 8k+7:8k for addr[1:0]=k. Halfword at addr[1]=h occupies bits 16h+15:16h.
- Alignment rule: size 01 needs addr[0]=0; size 10 needs addr[1:0]=0; size 11 is always an error.
- FSM states:
  - IDLE: req_ready=1. On accept, the next state is:
    - RESP(err) if the request is misaligned or uses the reserved size.
    - WR for SW.
    - RD for all other requests.
  - RD: presents mem_addr with mem_wr_rd=1. Always goes to CAP.
  - CAP: mem_data_out is valid.
    - Load: extract the lane, extend (signed uses the lane MSB), register into resp_rdata, go to RESP.
    - SB/SH: merge req_wdata low byte/half into the read word, register it in a write buffer, go to WR.
  - WR: mem_wr_rd=0, mem_data_in = write buffer (SW: latched wdata). Goes to RESP.
  - RESP: resp_valid=1 for exactly this cycle, then IDLE.
- mem_wr_rd is 0 only in WR, so the memory is never written outside WR.
- On an error response the memory is never accessed: mem_wr_rd stays 1 and no write occurs.
- resp_rdata and resp_err hold their values until the next RESP.

## Timing
- Latency is counted from the accept edge E0 to the cycle resp_valid is high:
  - SW: after E1.
  - Loads: after E2.
  - SB/SH: after E3.
  - Error: after E0.
- A new request can be accepted no earlier than the edge that ends RESP. Throughput is one request per (latency+1) cycles.
- Reset, including mid-operation, immediately forces:
  - state IDLE
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0
  - mem_wr_rd=1, mem_addr=0, mem_data_in=0
- An in-flight SB/SH or SW is aborted with no write. No response is issued for an aborted request.
- req_valid while not ready is ignored. The requester must hold the request until it is accepted.

## Structure
- Shared package lsu_pkg holds:
  - op field positions
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD
  - the FSM state enum
- Sub-module lsu_lane_align, purely combinational, performs:
  - load extract/extend (word, addr[1:0], size, unsigned → 32-bit)
  - store merge (old word, wdata, addr[1:0], size → new word)
- The top level contains only the FSM, latches and memory port.

## Test plan
- Memory preloaded with word 0x04 = 0x8899AABB; LB addr 0x13 → word 4 read, resp_rdata 0xFFFFFF88, resp_valid 2 cycles after accept; LBU same address → 0x00000088.
- LH addr 0x12 → 0xFFFF8899; LHU addr 0x10 → 0x0000AABB; LW addr 0x10 → 0x8899AABB.
- SB addr 0x11 wdata 0x000000CC → one write cycle, word 4 becomes 0x8899CCBB; subsequent LW returns it; resp_valid 3 cycles after accept.
- SW addr 0x20 wdata 0xDEADBEEF → mem_wr_rd=0 for exactly one cycle with mem_addr=8; resp after 1 cycle, resp_rdata=0, err=0.
- LW addr 0x12, SH addr 0x13, op size 11 → each gives resp_err=1 in the cycle after accept, no write occurs, and memory contents are unchanged.
- Assert rst during WR of an SB → no write, outputs at reset values, no resp_valid; next LW of that word returns the original data.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
// Op field layout, size codes, FSM states.
package lsu_pkg;

  localparam int OP_STORE = 3;
  localparam int OP_UNS   = 2;
  localparam int OP_SZ_HI = 1;
  localparam int OP_SZ_LO = 0;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RESP
  } state_e;

  // Misaligned or reserved-size request.
  function automatic logic lsu_bad(
    input logic [1:0] sz,
    input logic [1:0] lo
  );
    logic r;
    unique case (sz)
      SZ_BYTE: r = 1'b0;
      SZ_HALF: r = lo[0];
      SZ_WORD: r = |lo;
      SZ_RSVD: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane extraction for loads and
// lane merge for read-modify-write stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [4:0]  sh;
  logic [31:0] lane;
  logic [31:0] mask;
  logic        sx;

  // Shift the addressed lane down, then extend or merge.
  always_comb begin
    sh         = 5'd0;
    mask       = 32'hFFFF_FFFF;
    load_data  = word;
    sx         = 1'b0;
    unique case (1'b1)
      (size == SZ_BYTE): begin
        sh        = {addr_lo, 3'b000};
        mask      = 32'h0000_00FF << sh;
        lane      = word >> sh;
        sx        = ~uns & lane[7];
        load_data = {{24{sx}}, lane[7:0]};
      end
      (size == SZ_HALF): begin
        sh        = {addr_lo[1], 4'b0000};
        mask      = 32'h0000_FFFF << sh;
        lane      = word >> sh;
        sx        = ~uns & lane[15];
        load_data = {{16{sx}}, lane[15:0]};
      end
      default: begin
        lane      = word;
        load_data = word;
      end
    endcase
    store_word = (word & ~mask)
               | ((wdata << sh) & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: loads, stores,
// sub-word read-modify-write, alignment check.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data_in,
  output logic                  mem_wr_rd,
  input  logic [31:0]           mem_data_out
);

  localparam int AL = ADDR_WIDTH + 2;

  state_e        state_q, state_d;
  logic [3:0]    op_q;
  logic [AL-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   wbuf_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic          accept;
  logic          bad;
  logic          is_sw;
  logic [31:0]   ld_data;
  logic [31:0]   st_word;
  logic          unused_addr_hi;

  assign accept = req_valid & req_ready;
  assign bad    = lsu_bad(req_op[OP_SZ_HI:OP_SZ_LO],
                          req_addr[1:0]);
  assign is_sw  = req_op[OP_STORE]
                & (req_op[OP_SZ_HI:OP_SZ_LO] == SZ_WORD);

  // Upper byte-address bits lie outside the memory.
  assign unused_addr_hi = ^req_addr[31:AL];

  lsu_lane_align u_align (
    .word       (mem_data_out),
    .wdata      (wdata_q),
    .addr_lo    (addr_q[1:0]),
    .size       (op_q[OP_SZ_HI:OP_SZ_LO]),
    .uns        (op_q[OP_UNS]),
    .load_data  (ld_data),
    .store_word (st_word)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and port strobes.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_wr_rd  = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (accept)
          state_d = bad   ? S_RESP :
                    is_sw ? S_WR   : S_RD;
      end
      S_RD:  state_d = S_CAP;
      S_CAP: state_d = op_q[OP_STORE] ? S_WR : S_RESP;
      S_WR: begin
        mem_wr_rd = 1'b0;
        state_d   = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, write buffer, response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr[AL-1:0];
        wdata_q <= req_wdata;
        wbuf_q  <= req_wdata;
        if (bad) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
      if (state_q == S_CAP) begin
        if (op_q[OP_STORE]) begin
          wbuf_q <= st_word;
        end else begin
          rdata_q <= ld_data;
          err_q   <= 1'b0;
        end
      end
      if (state_q == S_WR) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  assign mem_addr    = addr_q[AL-1:2];
  assign mem_data_in = wbuf_q;
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised bench for load_store_unit with a
// byte-array reference memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data_in;
  logic        mem_wr_rd;
  logic [31:0] mem_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.ADDR_WIDTH(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_wr_rd    (mem_wr_rd),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  // Registered-address single-port memory.
  logic [31:0] mem [0:1023];
  logic [9:0]  raddr = '0;
  always @(posedge clk) begin
    if (!mem_wr_rd) mem[mem_addr] <= mem_data_in;
    raddr <= mem_addr;
  end
  assign mem_data_out = mem[raddr];

  // Write-cycle monitor.
  int          wr_cnt  = 0;
  logic [9:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  always @(posedge clk) begin
    if (!mem_wr_rd) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = mem_addr;
      wr_data = mem_data_in;
    end
  end

  // Reference: flat byte memory, little-endian.
  logic [7:0] rb [0:4095];

  function automatic int nbytes(logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit ref_bad(logic [3:0] op, logic [31:0] a);
    if (op[1:0] == 2'd3) return 1'b1;
    return (a % nbytes(op[1:0])) != 0;
  endfunction

  function automatic logic [31:0] ref_load(logic [3:0] op,
                                           logic [31:0] a);
    int n = nbytes(op[1:0]);
    logic [31:0] v = '0;
    logic [11:0] b = a[11:0];
    for (int i = 0; i < n; i++)
      v = v | (32'(rb[b + 12'(i)]) << (8 * i));
    if (!op[2] && n < 4 && v[8 * n - 1])
      v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic ref_store(logic [3:0] op, logic [31:0] a,
                           logic [31:0] wd);
    int n = nbytes(op[1:0]);
    logic [11:0] b = a[11:0];
    logic [31:0] t;
    for (int i = 0; i < n; i++) begin
      t = wd >> (8 * i);
      rb[b + 12'(i)] = t[7:0];
    end
  endtask

  function automatic logic [31:0] ref_word(int w);
    return {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
  endfunction

  // Expected edges after accept before resp_valid.
  function automatic int ref_lat(logic [3:0] op, logic [31:0] a);
    if (ref_bad(op, a)) return 0;
    if (!op[3])         return 2;
    if (op[1:0] == 2'd2) return 1;
    return 3;
  endfunction

  // One request; returns response and observed timing.
  task automatic do_req(input  logic [3:0]  op,
                        input  logic [31:0] a,
                        input  logic [31:0] wd,
                        output logic [31:0] rdata,
                        output logic        err,
                        output int          lat,
                        output int          nwr);
    int w0;
    int g = 0;
    @(negedge clk);
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = wd;
    w0        = wr_cnt;
    @(posedge clk);
    lat   = -1;
    rdata = 'x;
    err   = 1'bx;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_op    = 4'($urandom);
      req_addr  = $urandom;
      if (resp_valid) begin
        lat   = i;
        rdata = resp_rdata;
        err   = resp_err;
        break;
      end
    end
    nwr = wr_cnt - w0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({req_ready, resp_valid, resp_rdata, resp_err,
         mem_wr_rd, mem_addr, mem_data_in} !==
        {1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 10'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b rv=%b rd=%h err=%b wr_rd=%b ma=%h md=%h",
               req_ready, resp_valid, resp_rdata, resp_err,
               mem_wr_rd, mem_addr, mem_data_in);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_loads();
    logic [3:0]  ops [5] = '{4'b0000, 4'b0100, 4'b0001,
                             4'b0101, 4'b0010};
    logic [31:0] adr [5] = '{32'h13, 32'h13, 32'h12,
                             32'h10, 32'h10};
    logic [31:0] exp [5] = '{32'hFFFF_FF88, 32'h0000_0088,
                             32'hFFFF_8899, 32'h0000_AABB,
                             32'h8899_AABB};
    logic [31:0] rd;
    logic        er;
    int          lat, nwr;
    for (int i = 0; i < 5; i++) begin
      do_req(ops[i], adr[i], $urandom, rd, er, lat, nwr);
      n_checks++;
      if (rd !== exp[i] || er !== 1'b0) begin
        n_fail++;
        $display("FAIL load_data[%0d]: got %h err=%b, want %h err=0",
                 i, rd, er, exp[i]);
      end
      n_checks++;
      if (lat != 2 || nwr != 0) begin
        n_fail++;
        $display("FAIL load_timing[%0d]: lat=%0d wr=%0d, want 2/0",
                 i, lat, nwr);
      end
    end
  endtask

  task automatic test_stores();
    logic [31:0] rd;
    logic        er;
    int          lat, nwr;
    do_req(4'b1000, 32'h11, 32'h0000_00CC, rd, er, lat, nwr);
    ref_store(4'b1000, 32'h11, 32'h0000_00CC);
    n_checks++;
    if (lat != 3 || nwr != 1 || wr_addr !== 10'd4) begin
      n_fail++;
      $display("FAIL sb_timing: lat=%0d wr=%0d wa=%0d, want 3/1/4",
               lat, nwr, wr_addr);
    end
    n_checks++;
    if (mem[4] !== 32'h8899_CCBB || rd !== 0 || er !== 0) begin
      n_fail++;
      $display("FAIL sb_word: mem=%h rd=%h err=%b, want 8899ccbb/0/0",
               mem[4], rd, er);
    end
    do_req(4'b0010, 32'h10, $urandom, rd, er, lat, nwr);
    n_checks++;
    if (rd !== 32'h8899_CCBB) begin
      n_fail++;
      $display("FAIL sb_readback: got %h want 8899ccbb", rd);
    end
    do_req(4'b1010, 32'h20, 32'hDEAD_BEEF, rd, er, lat, nwr);
    ref_store(4'b1010, 32'h20, 32'hDEAD_BEEF);
    n_checks++;
    if (lat != 1 || nwr != 1 || wr_addr !== 10'd8 ||
        wr_data !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL sw_write: lat=%0d wr=%0d wa=%0d wd=%h",
               lat, nwr, wr_addr, wr_data);
    end
    n_checks++;
    if (rd !== 0 || er !== 0 || mem[8] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL sw_resp: rd=%h err=%b mem=%h", rd, er, mem[8]);
    end
  endtask

  task automatic test_errors();
    logic [3:0]  ops [3] = '{4'b0010, 4'b1001, 4'b1011};
    logic [31:0] adr [3] = '{32'h12, 32'h13, 32'h10};
    logic [31:0] rd;
    logic        er;
    int          lat, nwr;
    for (int i = 0; i < 3; i++) begin
      do_req(ops[i], adr[i], $urandom, rd, er, lat, nwr);
      n_checks++;
      if (er !== 1'b1 || rd !== 0 || lat != 0 || nwr != 0) begin
        n_fail++;
        $display("FAIL err_resp[%0d]: err=%b rd=%h lat=%0d wr=%0d",
                 i, er, rd, lat, nwr);
      end
      n_checks++;
      if (mem[4] !== ref_word(4)) begin
        n_fail++;
        $display("FAIL err_mem[%0d]: got %h want %h",
                 i, mem[4], ref_word(4));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  op;
    logic [31:0] a, wd, rd, exp;
    logic        er, ebad;
    int          lat, nwr, enwr;
    for (int k = 0; k < 80; k++) begin
      op       = 4'($urandom);
      a        = $urandom;
      a[11:0]  = 12'($urandom_range(0, 63));
      wd       = $urandom;
      ebad     = ref_bad(op, a);
      exp      = (ebad || op[3]) ? 32'h0 : ref_load(op, a);
      enwr     = (!ebad && op[3]) ? 1 : 0;
      do_req(op, a, wd, rd, er, lat, nwr);
      if (!ebad && op[3]) ref_store(op, a, wd);
      n_checks++;
      if (rd !== exp || er !== ebad || lat != ref_lat(op, a) ||
          nwr != enwr) begin
        n_fail++;
        $display("FAIL rand[%0d] op=%b a=%h: rd=%h err=%b lat=%0d wr=%0d want %h/%b/%0d/%0d",
                 k, op, a, rd, er, lat, nwr,
                 exp, ebad, ref_lat(op, a), enwr);
      end
    end
    for (int w = 0; w < 16; w++) begin
      n_checks++;
      if (mem[w] !== ref_word(w)) begin
        n_fail++;
        $display("FAIL mem_word[%0d]: got %h want %h",
                 w, mem[w], ref_word(w));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] orig, rd;
    logic        er;
    int          lat, nwr, g, w0, rv;
    orig = ref_word(4);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 4'b1000;
    req_addr  = 32'h11;
    req_wdata = 32'h0000_0055;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    g = 0;
    while (mem_wr_rd && g < 6) begin
      @(negedge clk);
      g++;
    end
    n_checks++;
    if (mem_wr_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_reach_wr: wr_rd=%b want 0", mem_wr_rd);
    end
    w0  = wr_cnt;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, resp_valid, resp_rdata, resp_err,
         mem_wr_rd, mem_addr, mem_data_in} !==
        {1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 10'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: ready=%b rv=%b rd=%h err=%b wr_rd=%b ma=%h md=%h",
               req_ready, resp_valid, resp_rdata, resp_err,
               mem_wr_rd, mem_addr, mem_data_in);
    end
    rv = 0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid) rv++;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) rv++;
    end
    n_checks++;
    if (wr_cnt != w0 || rv != 0) begin
      n_fail++;
      $display("FAIL rst_mid_abort: writes=%0d resp=%0d want 0/0",
               wr_cnt - w0, rv);
    end
    do_req(4'b0010, 32'h10, $urandom, rd, er, lat, nwr);
    n_checks++;
    if (rd !== orig || er !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_readback: got %h want %h", rd, orig);
    end
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 1024; i++) begin
      v = (i == 4) ? 32'h8899_AABB : $urandom;
      mem[i] <= v;
      rb[4*i]   = v[7:0];
      rb[4*i+1] = v[15:8];
      rb[4*i+2] = v[23:16];
      rb[4*i+3] = v[31:24];
    end
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
